// File: rtl/err_pkt_pkg.sv
// Shared types and helpers for the error-telemetry packet framer.
package err_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam logic [31:0] DEF_SYNC_WORD = 32'h5504_90EB;

  // Total bytes on the wire: sync header, payload, optional checksum.
  function automatic int unsigned pkt_len(input int unsigned n_ch,
                                          input int unsigned cnt_bytes,
                                          input int unsigned add_csum);
    return 32'd4 + n_ch * cnt_bytes + add_csum;
  endfunction

endpackage

// File: rtl/err_pkt_framer.sv
// Snapshots N_CH error counters on start and streams sync header, payload and
// optional mod-256 checksum over a valid/ready byte interface.
module err_pkt_framer
  import err_pkt_pkg::*;
#(
  parameter int unsigned N_CH      = 11,
  parameter int unsigned CNT_BYTES = 1,
  parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter bit          ADD_CSUM  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH*CNT_BYTES*8-1:0]   cnt_flat,
  input  logic                          start,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          busy,
  output logic                          done,
  output logic                          start_drop
);

  localparam int unsigned PAY_BYTES = N_CH * CNT_BYTES;
  localparam int unsigned PAY_W     = PAY_BYTES * 8;
  localparam int unsigned LEN       = pkt_len(N_CH, CNT_BYTES, ADD_CSUM ? 32'd1 : 32'd0);
  localparam int unsigned IDX_W     = $clog2(LEN + 1);

  localparam logic [IDX_W-1:0] HDR_END  = IDX_W'(3);
  localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(3 + PAY_BYTES);
  localparam logic [IDX_W-1:0] LEN_LAST = IDX_W'(LEN - 1);

  if (PAY_BYTES > 255 || CNT_BYTES == 0 || CNT_BYTES > 4 || N_CH == 0) begin : g_param_err
    $error("err_pkt_framer: N_CH*CNT_BYTES must be 1..255 and CNT_BYTES 1..4");
  end

  // Reorder the counters into wire order (channel 0 first, MS byte first) so
  // the shifter only ever pops its low byte.
  logic [PAY_W-1:0] snap;
  for (genvar j = 0; j < PAY_BYTES; j++) begin : g_snap
    localparam int unsigned SRC = (j / CNT_BYTES) * CNT_BYTES + (CNT_BYTES - 1 - (j % CNT_BYTES));
    assign snap[j*8 +: 8] = cnt_flat[SRC*8 +: 8];
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [PAY_W-1:0] shreg;
  logic [7:0]       csum;
  logic [7:0]       sync_byte;

  assign idx_nxt = idx + IDX_W'(1);

  // Header byte that follows the one currently presented.
  always_comb begin
    sync_byte = SYNC_WORD[7:0];
    case (idx_nxt[1:0])
      2'd1:    sync_byte = SYNC_WORD[15:8];
      2'd2:    sync_byte = SYNC_WORD[23:16];
      2'd3:    sync_byte = SYNC_WORD[31:24];
      default: sync_byte = SYNC_WORD[7:0];
    endcase
  end

  // FSM, payload shifter and checksum accumulator; idx counts the byte on dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      csum       <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      done       <= 1'b0;
      start_drop <= start && busy;
      case (state)
        IDLE: begin
          if (start) begin
            shreg      <= snap;
            csum       <= 8'h00;
            idx        <= '0;
            dout       <= SYNC_WORD[7:0];
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
            busy       <= 1'b1;
            state      <= HDR;
          end
        end
        default: begin
          if (dout_valid && dout_ready) begin
            if (dout_last) begin
              state      <= IDLE;
              idx        <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              idx       <= idx_nxt;
              dout_last <= (idx_nxt == LEN_LAST);
              if (idx < HDR_END) begin
                dout  <= sync_byte;
                state <= HDR;
              end else if (idx < PAY_END) begin
                dout  <= shreg[7:0];
                shreg <= shreg >> 8;
                csum  <= csum + shreg[7:0];
                state <= PAY;
              end else begin
                dout  <= csum;
                state <= CSUM;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_err_pkt_framer.sv
// Scoreboard bench for err_pkt_framer: a packet-level model fills the expected
// queue on each accepted start, a negedge monitor checks every transfer.
module tb_err_pkt_framer;

  localparam int unsigned NA = 11, CBA = 1, NB = 2, CBB = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NA*CBA*8-1:0] cnt_a;
  logic [NB*CBB*8-1:0] cnt_b;
  logic start_a, start_b, dout_ready;
  logic [7:0] dout_a, dout_b;
  logic valid_a, valid_b, last_a, last_b, busy_a, busy_b;
  logic done_a, done_b, drop_a, drop_b;

  err_pkt_framer #(.N_CH(NA), .CNT_BYTES(CBA), .SYNC_WORD(32'h5504_90EB), .ADD_CSUM(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .cnt_flat(cnt_a), .start(start_a), .dout(dout_a),
    .dout_valid(valid_a), .dout_ready(dout_ready), .dout_last(last_a), .busy(busy_a),
    .done(done_a), .start_drop(drop_a));

  err_pkt_framer #(.N_CH(NB), .CNT_BYTES(CBB), .SYNC_WORD(32'h5504_90EB), .ADD_CSUM(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .cnt_flat(cnt_b), .start(start_b), .dout(dout_b),
    .dout_valid(valid_b), .dout_ready(dout_ready), .dout_last(last_b), .busy(busy_b),
    .done(done_b), .start_drop(drop_b));

  // Monitor observes whichever DUT is under test.
  logic sel = 1'b0;
  logic [7:0] m_dout;
  logic m_valid, m_last, m_busy, m_done, m_drop, m_start;
  assign m_dout  = sel ? dout_b  : dout_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_last  = sel ? last_b  : last_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_drop  = sel ? drop_b  : drop_a;
  assign m_start = sel ? start_b : start_a;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want none at %0t", name, act, $time);
  endtask

  // Reference model state.
  logic [8:0] q[$];
  logic [8:0] e;
  bit inflight = 0, done_due = 0, drop_due = 0, hold = 0, first_seen = 0;
  logic [7:0] hold_dout;
  logic hold_last;
  int cyc = 0, pkts = 0, drops = 0, accept_cyc = 0, first_cyc = 0, last_cyc = 0;

  // Expected packet from the spec rules: header LS first, channels in order,
  // MS byte first within a channel, optional sum of payload bytes.
  function automatic void push_pkt(input logic [87:0] flat, input int n, input int cb, input bit add_cs);
    logic [31:0] sw;
    logic [7:0] s, b;
    sw = 32'h5504_90EB;
    s = 8'h00;
    for (int i = 0; i < 4; i++) q.push_back({1'b0, sw[i*8 +: 8]});
    for (int k = 0; k < n; k++)
      for (int bb = cb - 1; bb >= 0; bb--) begin
        b = flat[(k*cb + bb)*8 +: 8];
        s = s + b;
        q.push_back({(!add_cs && k == n - 1 && bb == 0), b});
      end
    if (add_cs) q.push_back({1'b1, s});
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      inflight = 0; done_due = 0; drop_due = 0; hold = 0;
    end else begin
      chk("busy", {31'b0, m_busy}, {31'b0, inflight});
      if (done_due) chk("done", {31'b0, m_done}, 1);
      else if (m_done) fail_now("done_spurious", {31'b0, m_done});
      if (drop_due) begin
        chk("start_drop", {31'b0, m_drop}, 1);
        if (m_drop) drops++;
      end else if (m_drop) fail_now("start_drop_spurious", {31'b0, m_drop});
      if (hold) begin
        chk("hold_valid", {31'b0, m_valid}, 1);
        chk("hold_dout", {24'b0, m_dout}, {24'b0, hold_dout});
        chk("hold_last", {31'b0, m_last}, {31'b0, hold_last});
      end
      if (inflight && !m_valid) fail_now("valid_drop", {31'b0, m_valid});
      done_due = 0;
      drop_due = 0;
      if (m_start) begin
        if (inflight) drop_due = 1;
        else begin
          if (sel) push_pkt({56'b0, cnt_b}, NB, CBB, 1'b0);
          else push_pkt(cnt_a, NA, CBA, 1'b1);
          inflight = 1;
          accept_cyc = cyc;
          first_seen = 0;
        end
      end
      hold = m_valid && !dout_ready;
      hold_dout = m_dout;
      hold_last = m_last;
      if (m_valid && dout_ready) begin
        if (q.size() == 0) fail_now("unexpected_byte", {24'b0, m_dout});
        else begin
          e = q.pop_front();
          chk("byte", {24'b0, m_dout}, {24'b0, e[7:0]});
          chk("last", {31'b0, m_last}, {31'b0, e[8]});
          if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
          if (q.size() == 0) begin
            inflight = 0; done_due = 1; pkts++; last_cyc = cyc;
          end
        end
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  int rmode = 0, rphase = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: dout_ready = 1'b1;
      1: begin dout_ready = (rphase % 4 == 0) || (rphase % 4 == 3); rphase++; end
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((inflight || q.size() != 0) && n < 400) begin tick(); n++; end
    if (n >= 400) fail_now("timeout", n);
    tick();
    tick();
  endtask

  task automatic ramp_a();
    for (int i = 0; i < NA; i++) cnt_a[i*8 +: 8] = 8'(i + 1);
  endtask

  task automatic rand_a();
    for (int i = 0; i < NA; i++) cnt_a[i*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, d0;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; dout_ready = 1'b1;
    cnt_a = '0; cnt_b = '0;
    tick(); tick();
    chk("rst_dout_a", {24'b0, dout_a}, 0);   chk("rst_valid_a", {31'b0, valid_a}, 0);
    chk("rst_last_a", {31'b0, last_a}, 0);   chk("rst_busy_a", {31'b0, busy_a}, 0);
    chk("rst_done_a", {31'b0, done_a}, 0);   chk("rst_drop_a", {31'b0, drop_a}, 0);
    chk("rst_dout_b", {24'b0, dout_b}, 0);   chk("rst_valid_b", {31'b0, valid_b}, 0);
    chk("rst_busy_b", {31'b0, busy_b}, 0);   chk("rst_done_b", {31'b0, done_b}, 0);
    rst_n = 1'b1;
    tick(); tick();

    // Ramp counters, always ready: 16 bytes on consecutive cycles.
    ramp_a();
    p0 = pkts;
    pulse_start();
    wait_idle();
    chk("pkt1_count", pkts - p0, 1);
    chk("first_latency", first_cyc - accept_cyc, 1);
    chk("span_a", last_cyc - first_cyc, 15);

    // 1,0,0,1 backpressure.
    rmode = 1; rphase = 0;
    tick();
    pulse_start();
    wait_idle();
    rmode = 0;

    // Snapshot isolation: counters change right after the accepting edge.
    tick();
    pulse_start();
    cnt_a = {NA{8'hFF}};
    wait_idle();
    ramp_a();

    // Overlapping start during payload byte 5.
    p0 = pkts; d0 = drops;
    pulse_start();
    repeat (7) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_idle();
    repeat (20) tick();
    chk("overlap_pkts", pkts - p0, 1);
    chk("overlap_drops", drops - d0, 1);

    // Start held high: back-to-back packets with one idle cycle between.
    p0 = pkts;
    start_a = 1'b1;
    repeat (50) tick();
    start_a = 1'b0;
    wait_idle();
    chk("held_pkts", pkts - p0, 3);

    // Random counters, random ready, occasional stray starts.
    rmode = 2;
    for (int t = 0; t < 15; t++) begin
      rand_a();
      repeat ($urandom_range(0, 3)) tick();
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 30)) tick();
        pulse_start();
      end
      wait_idle();
    end
    rmode = 0;

    // Reset while header byte 3 is on the wire.
    ramp_a();
    tick();
    p0 = pkts;
    pulse_start();
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", {24'b0, dout_a}, 0);  chk("mid_rst_valid", {31'b0, valid_a}, 0);
    chk("mid_rst_last", {31'b0, last_a}, 0);  chk("mid_rst_busy", {31'b0, busy_a}, 0);
    chk("mid_rst_done", {31'b0, done_a}, 0);  chk("mid_rst_drop", {31'b0, drop_a}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_pkt", pkts - p0, 0);
    pulse_start();
    wait_idle();
    chk("post_rst_pkt", pkts - p0, 1);

    // Two 16-bit channels, no checksum.
    sel = 1'b1;
    cnt_b = {16'hABCD, 16'h1234};
    tick();
    p0 = pkts;
    pulse_start();
    wait_idle();
    chk("pkt_b_count", pkts - p0, 1);
    chk("span_b", last_cyc - first_cyc, 7);
    rmode = 2;
    for (int t = 0; t < 6; t++) begin
      cnt_b = 32'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      pulse_start();
      wait_idle();
    end
    rmode = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
